tt_lut_checker: RTL
===================

Name: tt_lut_checker

Overview:
- Parametrised successor to the team's fixed 4-input NOR-netlist truth-table cells: holds a runtime-loadable 2^N_IN-bit truth table.
- Serves registered single-vector evaluations.
- Runs an exhaustive equivalence sweep against an external synthesised gate netlist (DUT), counting and locating mismatches.
- Sits beside generated gate designs in the equivalence flow, replacing per-function hand-written checkers.

Parameters:
N_IN, 4, number of truth-table inputs (1..8)
TT_INIT, 16'h3B60, truth table loaded at reset (width 2^N_IN; bit k = output for input vector k)
DUT_LAT, 0, DUT latency in cycles from dut_in to dut_out (0 = combinational, 0..7)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
cfg_valid  in  1  serial truth-table bit strobe
cfg_bit  in  1  truth-table bit, LSB (index 0) first
cfg_ready  out  1  high when load accepted (not busy)
tt_loaded  out  1  table complete and valid
eval_valid  in  1  evaluation request
eval_in  in  N_IN  input vector to evaluate
eval_out_valid  out  1  evaluation result strobe
eval_out  out  1  evaluation result
start  in  1  begin equivalence sweep
busy  out  1  sweep or drain in progress
dut_in  out  N_IN  vector driven to DUT
dut_out  in  1  DUT response
done  out  1  one-cycle sweep-complete pulse
pass  out  1  last sweep had zero mismatches
err_count  out  N_IN+1  mismatches in last sweep
first_fail  out  N_IN  lowest failing vector index of last sweep

Behaviour:
- Reset: TT register = TT_INIT, tt_loaded=1, load index=0, state IDLE; busy=0, done=0, pass=0, err_count=0, first_fail=0, dut_in=0, eval_out_valid=0, eval_out=0, cfg_ready=1. Reset mid-sweep or mid-load aborts immediately with the same values.
- cfg_ready = ~busy.
- Load: on cfg_valid && cfg_ready, TT[idx] <= cfg_bit and idx increments.
  - idx==0 write clears tt_loaded.
  - Write of idx==2^N_IN-1 sets tt_loaded=1 and wraps idx to 0; a following cfg_valid starts a fresh load.
  - cfg_valid while busy ignored.
- Eval: independent of sweep. eval_valid at cycle t -> eval_out_valid=1 at t+1.
  - eval_out = TT[eval_in] if tt_loaded, else 0.
  - Same-cycle cfg write is not visible to that eval.
  - Back-to-back requests give one result per cycle.
- Sweep FSM: IDLE -> SWEEP -> DRAIN -> IDLE.
  - IDLE: start && tt_loaded at cycle t -> SWEEP at t+1. Clear err_count, first_fail, pass. busy=1 from t+1.
  - start with tt_loaded=0, or any start while busy, is ignored.
  - SWEEP: dut_in = k during cycle t+1+k, for k=0..2^N_IN-1, then -> DRAIN.
  - Drain lasts DUT_LAT cycles; with DUT_LAT=0, SWEEP -> IDLE directly.
  - dut_in holds its last value after the sweep.
- Compare:
  - A valid/index delay line of depth DUT_LAT aligns each index with dut_out; dut_out for vector k is sampled at cycle t+1+k+DUT_LAT.
  - Mismatch when dut_out != TT[k]: err_count increments.
  - On the first mismatch only, first_fail=k.
- Completion: at cycle t+2^N_IN+DUT_LAT+1, done=1 for one cycle, busy=0, pass=(err_count==0).
  - err_count/first_fail/pass hold until next accepted start or rst.
  - first_fail=0 when err_count=0.
  - err_count max 2^N_IN; no overflow.

Test Plan:
- After rst, eval_in=5,13,0,15 back-to-back -> eval_out 1,1,0,0 on consecutive cycles, each one cycle after request.
- Serial load 16 ones -> tt_loaded drops after bit 0 and rises after bit 15; eval_in=0 -> 1. Eval during the load -> eval_out=0.
- DUT_LAT=0, DUT models 0x3B60, start at t -> dut_in 0..15 on t+1..t+16; done at t+17, pass=1, err_count=0.
- DUT models 0x3B61 -> err_count=1, first_fail=0, pass=0. DUT models 0xC49F -> err_count=16, first_fail=0.
- DUT_LAT=2, DUT = 0x3B60 with bit 9 flipped, registered twice -> done at t+19, err_count=1, first_fail=9. A second start while busy is ignored, and cfg_valid while busy does not alter TT.
- rst asserted at t+8 of a sweep -> next cycle busy=0, done=0, err_count=0; eval_in=5 -> 1 (TT back to TT_INIT).

Source files
------------

// File: rtl/tt_lut_checker.sv
// Runtime-loadable truth-table checker. Holds a 2^N_IN-bit table, answers
// registered single-vector lookups, and sweeps every input vector through an
// external gate netlist, counting mismatches and locating the lowest failing one.
module tt_lut_checker #(
    parameter int                      N_IN    = 4,
    parameter logic [(1<<N_IN)-1:0]    TT_INIT = 16'h3B60,
    parameter int                      DUT_LAT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_ready,
    output logic            tt_loaded,
    input  logic            eval_valid,
    input  logic [N_IN-1:0] eval_in,
    output logic            eval_out_valid,
    output logic            eval_out,
    input  logic            start,
    output logic            busy,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail
);

    localparam int              DEPTH = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST  = {N_IN{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN} state_t;

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [N_IN:0]     err_q;
    logic [N_IN-1:0]   first_fail_q;
    logic [N_IN-1:0]   dut_in_q;
    logic [2:0]        drain_q;

    logic [DEPTH-1:0]  tt_q;
    logic [N_IN-1:0]   idx_q;
    logic              loaded_q;

    logic              eval_v_q;
    logic              eval_o_q;

    // Compare-side view of the sweep: index aligned with the DUT response.
    logic              cmp_v;
    logic [N_IN-1:0]   cmp_k;
    logic              sweep_act;
    logic              mismatch;
    logic              last_cmp;

    assign sweep_act = (state_q == S_SWEEP);

    generate
        if (DUT_LAT == 0) begin : g_nolat
            assign cmp_v = sweep_act;
            assign cmp_k = dut_in_q;
        end else begin : g_lat
            logic [DUT_LAT-1:0]           pv_q;
            logic [DUT_LAT-1:0][N_IN-1:0] pk_q;

            // Delay line carrying (valid, index) alongside the DUT pipeline.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pv_q <= '0;
                    pk_q <= '0;
                end else begin
                    pv_q[0] <= sweep_act;
                    pk_q[0] <= dut_in_q;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        pv_q[i] <= pv_q[i-1];
                        pk_q[i] <= pk_q[i-1];
                    end
                end
            end

            assign cmp_v = pv_q[DUT_LAT-1];
            assign cmp_k = pk_q[DUT_LAT-1];
        end
    endgenerate

    assign mismatch = cmp_v && (dut_out != tt_q[cmp_k]);
    assign last_cmp = cmp_v && (cmp_k == LAST);

    // Sweep FSM plus mismatch accounting; done fires on the last aligned compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            first_fail_q <= '0;
            dut_in_q     <= '0;
            drain_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && loaded_q) begin
                        state_q      <= S_SWEEP;
                        busy_q       <= 1'b1;
                        dut_in_q     <= '0;
                        err_q        <= '0;
                        first_fail_q <= '0;
                        pass_q       <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    if (dut_in_q == LAST) begin
                        if (DUT_LAT == 0) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DRAIN;
                            drain_q <= '0;
                        end
                    end else begin
                        dut_in_q <= dut_in_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == 3'(DUT_LAT - 1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        drain_q <= drain_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (mismatch) begin
                err_q <= err_q + (N_IN+1)'(1);
                if (err_q == '0) begin
                    first_fail_q <= cmp_k;
                end
            end
            if (last_cmp) begin
                done_q <= 1'b1;
                pass_q <= (err_q == '0) && !mismatch;
            end
        end
    end

    // Serial table load, LSB first; blocked while a sweep is running.
    always_ff @(posedge clk) begin
        if (rst) begin
            tt_q     <= TT_INIT;
            idx_q    <= '0;
            loaded_q <= 1'b1;
        end else if (cfg_valid && !busy_q) begin
            tt_q[idx_q] <= cfg_bit;
            if (idx_q == LAST) begin
                loaded_q <= 1'b1;
                idx_q    <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
                if (idx_q == '0) begin
                    loaded_q <= 1'b0;
                end
            end
        end
    end

    // Registered lookup; reads the table as it stood before this cycle's write.
    always_ff @(posedge clk) begin
        if (rst) begin
            eval_v_q <= 1'b0;
            eval_o_q <= 1'b0;
        end else begin
            eval_v_q <= eval_valid;
            eval_o_q <= eval_valid && loaded_q && tt_q[eval_in];
        end
    end

    assign cfg_ready      = ~busy_q;
    assign tt_loaded      = loaded_q;
    assign eval_out_valid = eval_v_q;
    assign eval_out       = eval_o_q;
    assign busy           = busy_q;
    assign dut_in         = dut_in_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail     = first_fail_q;

endmodule
